// File: rtl/mkgauss_ctrl_if.sv
// Streaming bundle around mkgauss_ctrl: random-word source, sampler r1/r2 and val,
// and the downstream sample output. The controller is the master side.
interface mkgauss_ctrl_if #(
    parameter int MAX_LOGN = 10
);
    logic                rnd_valid;
    logic                rnd_ready;
    logic [63:0]         rnd_data;
    logic                r1_valid;
    logic [63:0]         r1;
    logic                r2_valid;
    logic [63:0]         r2;
    logic                val_valid;
    logic [31:0]         val;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_data;
    logic [MAX_LOGN-1:0] out_idx;

    modport master (
        input  rnd_valid, rnd_data, val_valid, val, out_ready,
        output rnd_ready, r1_valid, r1, r2_valid, r2, out_valid, out_data, out_idx
    );

    modport slave (
        output rnd_valid, rnd_data, val_valid, val, out_ready,
        input  rnd_ready, r1_valid, r1, r2_valid, r2, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/mkgauss_ctrl.sv
// Batch sequencer for the mkgauss sampler: feeds r1/r2 word pairs, buffers the
// returned samples in a small FIFO and streams them out with an index.
module mkgauss_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LOGN   = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [3:0]     logn,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           err,
    mkgauss_ctrl_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam int NW = MAX_LOGN + 1;

    typedef enum logic [1:0] {IDLE, ISSUE_R1, ISSUE_R2, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] issued_q, issued_d;
    logic [NW-1:0] delivered_q, delivered_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          r1_valid_q, r1_valid_d;
    logic          r2_valid_q, r2_valid_d;
    logic [63:0]   r1_q, r1_d;
    logic [63:0]   r2_q, r2_d;

    logic credit;
    logic rnd_ready;
    logic rnd_fire;
    logic out_valid;
    logic pop;
    logic fifo_full;
    logic accept_val;
    logic push;
    logic overflow;

    // Samples already requested but not yet returned must all fit in the FIFO,
    // because the sampler cannot be stalled.
    assign credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < SW'(FIFO_DEPTH);
    assign rnd_ready  = (state_q == ISSUE_R1) ? credit : (state_q == ISSUE_R2);
    assign rnd_fire   = bus.rnd_valid & rnd_ready;
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid & bus.out_ready;
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign accept_val = bus.val_valid & (inflight_q != '0);
    assign push       = accept_val & (~fifo_full | pop);
    assign overflow   = accept_val & fifo_full & ~pop;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = inflight_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        r1_valid_d  = 1'b0;
        r2_valid_d  = 1'b0;
        r1_d        = r1_q;
        r2_d        = r2_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.val;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            delivered_d = delivered_q + NW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (accept_val) begin
            inflight_d = inflight_q - CW'(1);
        end
        if (overflow) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(logn) > MAX_LOGN) begin
                        err_d = 1'b1;
                    end else begin
                        n_d         = NW'(1) << logn;
                        issued_d    = '0;
                        delivered_d = '0;
                        err_d       = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = ISSUE_R1;
                    end
                end
            end
            ISSUE_R1: begin
                if (rnd_fire) begin
                    r1_d       = bus.rnd_data;
                    r1_valid_d = 1'b1;
                    state_d    = ISSUE_R2;
                end
            end
            ISSUE_R2: begin
                if (rnd_fire) begin
                    r2_d       = bus.rnd_data;
                    r2_valid_d = 1'b1;
                    inflight_d = inflight_d + CW'(1);
                    issued_d   = issued_q + NW'(1);
                    state_d    = (issued_q + NW'(1) == n_q) ? DRAIN : ISSUE_R1;
                end
            end
            DRAIN: begin
                if (delivered_q == n_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; late sampler returns then hit the zero-inflight drop path.
        if (abort) begin
            state_d    = IDLE;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            r1_valid_d = 1'b0;
            r2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            r1_valid_q  <= 1'b0;
            r2_valid_q  <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            r1_valid_q  <= r1_valid_d;
            r2_valid_q  <= r2_valid_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign bus.rnd_ready = rnd_ready;
    assign bus.r1_valid  = r1_valid_q;
    assign bus.r1        = r1_q;
    assign bus.r2_valid  = r2_valid_q;
    assign bus.r2        = r2_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_idx   = delivered_q[MAX_LOGN-1:0];
endmodule

// File: tb/tb_mkgauss_ctrl.sv
// Directed bench for mkgauss_ctrl: models the random source and the sampler, and
// scoreboards the words issued as r1/r2 and the samples streamed out.
module tb_mkgauss_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_LOGN   = 10;

    typedef struct {
        logic [31:0] data;
        int          idx;
    } sample_t;

    typedef struct {
        int due;
        int epoch;
    } pend_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] logn;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;

    mkgauss_ctrl_if #(.MAX_LOGN(MAX_LOGN)) bus ();

    mkgauss_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_LOGN(MAX_LOGN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .logn  (logn),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycleCnt = 0;
    int          epoch = 0;
    int          batchPushes = 0;
    int          doneCount = 0;
    int          deliveredCount = 0;
    int          r1Count = 0;
    int          r2Count = 0;
    int          wordsConsumed = 0;
    int          lateVals = 0;
    bit          expectR1 = 1'b1;
    bit          rndOn = 1'b0;
    bit          rndToggle = 1'b0;
    logic [63:0] nextWord = 64'hC0DE_0000_0000_0001;

    sample_t     expQ[$];
    logic [63:0] wordQ[$];
    pend_t       pendQ[$];
    logic [31:0] sampVals[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Random-word source and sampler model, both driven just after the rising edge.
    // The sampler answers each r2 pulse two cycles later; returns belonging to an
    // aborted or reset batch are still driven but never expected at the output.
    always @(posedge clk) begin
        pend_t       p;
        logic [31:0] v;
        cycleCnt++;
        #1;
        bus.rnd_valid = rndOn && (!rndToggle || (cycleCnt % 4 == 0));
        bus.rnd_data  = nextWord;
        bus.val_valid = 1'b0;
        bus.val       = '0;
        if (pendQ.size() > 0 && pendQ[0].due <= cycleCnt) begin
            p = pendQ.pop_front();
            v = (sampVals.size() > 0) ? sampVals.pop_front() : 32'($urandom);
            bus.val_valid = 1'b1;
            bus.val       = v;
            if (p.epoch == epoch) begin
                expQ.push_back('{v, batchPushes});
                batchPushes++;
            end else begin
                lateVals++;
            end
        end
    end

    // Observe everything on the falling edge: check r1/r2 against consumed words,
    // record new handshakes, and compare delivered samples with the scoreboard.
    always @(negedge clk) begin
        sample_t s;
        if (bus.r1_valid) begin
            r1Count++;
            checkOutput("r1_order", expectR1, 1'b1);
            checkOutput("r1_r2_overlap", bus.r2_valid, 1'b0);
            checkOutput("r1_word_queued", wordQ.size(), 1);
            if (wordQ.size() > 0) checkOutput("r1_data", bus.r1, wordQ.pop_front());
            expectR1 = 1'b0;
        end
        if (bus.r2_valid) begin
            r2Count++;
            checkOutput("r2_order", expectR1, 1'b0);
            checkOutput("r2_word_queued", wordQ.size(), 1);
            if (wordQ.size() > 0) checkOutput("r2_data", bus.r2, wordQ.pop_front());
            pendQ.push_back('{cycleCnt + 2, epoch});
            expectR1 = 1'b1;
        end
        if (bus.rnd_valid === 1'b1 && bus.rnd_ready === 1'b1) begin
            wordQ.push_back(bus.rnd_data);
            wordsConsumed++;
            nextWord = nextWord + 64'h0000_0001_0000_0003;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            deliveredCount++;
            checkOutput("out_expected", expQ.size() > 0, 1'b1);
            if (expQ.size() > 0) begin
                s = expQ.pop_front();
                checkOutput("out_data", bus.out_data, s.data);
                checkOutput("out_idx", bus.out_idx, s.idx);
            end
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] n);
        batchPushes    = 0;
        doneCount      = 0;
        deliveredCount = 0;
        r1Count        = 0;
        r2Count        = 0;
        wordsConsumed  = 0;
        start = 1'b1;
        logn  = n;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        for (int i = 0; i < budget && doneCount == 0; i++) tick();
        repeat (3) tick();
        checkOutput({tag, "_done_once"}, doneCount, 1);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        logn          = '0;
        abort         = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_rnd_ready", bus.rnd_ready, 1'b0);
        checkOutput("rst_r1_valid", bus.r1_valid, 1'b0);
        checkOutput("rst_r2_valid", bus.r2_valid, 1'b0);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_idx", bus.out_idx, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] batch logn=2 with fixed sample values");
        rndOn = 1'b1;
        bus.out_ready = 1'b1;
        sampVals = '{32'sd5, -32'sd3, 32'sd0, -32'sd7};
        applyStimulus(4'd2);
        checkOutput("t1_busy", busy, 1'b1);
        waitDone("t1", 200);
        checkOutput("t1_pairs", r2Count, 4);
        checkOutput("t1_delivered", deliveredCount, 4);
        checkOutput("t1_sb_empty", expQ.size(), 0);
        checkOutput("t1_err", err, 1'b0);

        $display("[TB] batch logn=3 with output held off");
        bus.out_ready = 1'b0;
        applyStimulus(4'd3);
        repeat (40) tick();
        checkOutput("t2_r1_count", r1Count, FIFO_DEPTH);
        checkOutput("t2_r2_count", r2Count, FIFO_DEPTH);
        checkOutput("t2_rnd_ready", bus.rnd_ready, 1'b0);
        checkOutput("t2_out_valid", bus.out_valid, 1'b1);
        checkOutput("t2_err", err, 1'b0);
        bus.out_ready = 1'b1;
        waitDone("t2", 400);
        checkOutput("t2_delivered", deliveredCount, 8);
        checkOutput("t2_sb_empty", expQ.size(), 0);

        $display("[TB] batch logn=1 with sparse random words");
        rndToggle = 1'b1;
        applyStimulus(4'd1);
        waitDone("t3", 300);
        checkOutput("t3_words", wordsConsumed, 4);
        checkOutput("t3_pairs", r2Count, 2);
        checkOutput("t3_delivered", deliveredCount, 2);
        rndToggle = 1'b0;

        $display("[TB] bad logn then logn=0");
        applyStimulus(4'd11);
        checkOutput("t4_err_set", err, 1'b1);
        checkOutput("t4_busy_idle", busy, 1'b0);
        tick();
        checkOutput("t4_rnd_ready_idle", bus.rnd_ready, 1'b0);
        applyStimulus(4'd0);
        checkOutput("t4_err_cleared", err, 1'b0);
        checkOutput("t4_busy", busy, 1'b1);
        waitDone("t4", 200);
        checkOutput("t4_delivered", deliveredCount, 1);

        $display("[TB] abort after two pairs");
        bus.out_ready = 1'b0;
        lateVals = 0;
        applyStimulus(4'd3);
        for (int i = 0; i < 200 && r2Count < 2; i++) tick();
        checkOutput("t5_two_pairs", r2Count, 2);
        abort = 1'b1;
        epoch++;
        tick();
        abort = 1'b0;
        expQ.delete();
        wordQ.delete();
        expectR1 = 1'b1;
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_out_valid", bus.out_valid, 1'b0);
        repeat (10) tick();
        checkOutput("t5_late_val_seen", lateVals > 0, 1'b1);
        checkOutput("t5_err", err, 1'b0);
        checkOutput("t5_out_valid_late", bus.out_valid, 1'b0);
        checkOutput("t5_no_done", doneCount, 0);
        bus.out_ready = 1'b1;
        applyStimulus(4'd2);
        waitDone("t5", 200);
        checkOutput("t5_delivered", deliveredCount, 4);
        checkOutput("t5_err_after", err, 1'b0);

        $display("[TB] reset during r2 issue");
        applyStimulus(4'd3);
        for (int i = 0; i < 50 && bus.r1_valid !== 1'b1; i++) @(negedge clk);
        checkOutput("t6_in_r2", bus.r1_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_done", done, 1'b0);
        checkOutput("t6_err", err, 1'b0);
        checkOutput("t6_rnd_ready", bus.rnd_ready, 1'b0);
        checkOutput("t6_r1_valid", bus.r1_valid, 1'b0);
        checkOutput("t6_r2_valid", bus.r2_valid, 1'b0);
        checkOutput("t6_r1", bus.r1, 64'h0);
        checkOutput("t6_r2", bus.r2, 64'h0);
        checkOutput("t6_out_valid", bus.out_valid, 1'b0);
        checkOutput("t6_out_data", bus.out_data, 32'h0);
        checkOutput("t6_out_idx", bus.out_idx, 0);
        pendQ.delete();
        epoch++;
        expQ.delete();
        wordQ.delete();
        expectR1 = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("t6_idle_busy", busy, 1'b0);
        checkOutput("t6_idle_rnd_ready", bus.rnd_ready, 1'b0);
        applyStimulus(4'd0);
        waitDone("t6", 200);
        checkOutput("t6_delivered", deliveredCount, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mkgauss_ctrl.md
Name: mkgauss_ctrl

Overview:
- Sequencer in front of the mkgauss Gaussian sampler.
- On start, pulls 64-bit random words from a PRNG/SHAKE stream and issues them to the sampler as r1/r2 pairs, one pair per sample, for N = 2^logn samples.
- Sampler outputs are collected in a small FIFO and streamed out with ready backpressure and a sample index.
- The sampler has no backpressure, so a credit scheme guarantees the FIFO never overflows.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; also the max outstanding samples (power of 2, ≥2)
- MAX_LOGN, 10, largest accepted logn; sets out_idx width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a batch; sampled only in IDLE
- logn  in  4  batch size exponent, sampled with start; N = 1<<logn
- abort  in  1  synchronous flush, returns the block to IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last sample is delivered
- err  out  1  sticky: bad logn or FIFO overflow; cleared by the next accepted start
- rnd_valid  in  1  random word available
- rnd_ready  out  1  controller consumes rnd_data this cycle
- rnd_data  in  64  random word
- r1_valid  out  1  to sampler: r1 word valid, one-cycle pulse
- r1  out  64  to sampler: first word of pair
- r2_valid  out  1  to sampler: r2 word valid, one-cycle pulse
- r2  out  64  to sampler: second word of pair
- val_valid  in  1  from sampler: sample valid
- val  in  32  from sampler: signed sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  32  signed sample
- out_idx  out  MAX_LOGN  sample index, 0..N-1

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters zero; FIFO empty. busy, done, err, rnd_ready, r1_valid, r2_valid, out_valid = 0; r1, r2, out_data, out_idx = 0.
- States: IDLE, ISSUE_R1, ISSUE_R2, DRAIN.
- IDLE:
  - start=1 and logn ≤ MAX_LOGN: latch N, clear issued/delivered counters, clear err, busy=1, go ISSUE_R1.
  - start=1 and logn > MAX_LOGN: set err, stay IDLE.
  - start outside IDLE is ignored.
- Credit: inflight = pairs issued minus vals received. Issue is allowed when inflight + fifo_count < FIFO_DEPTH.
- ISSUE_R1:
  - rnd_ready = credit available. This is a combinational function of registered state and must not depend on rnd_valid.
  - On rnd_valid & rnd_ready: register r1 = rnd_data; r1_valid pulses the next cycle; go ISSUE_R2.
- ISSUE_R2:
  - rnd_ready = 1.
  - On handshake: register r2; r2_valid pulses the next cycle; inflight+1; issued+1.
  - If issued == N, go DRAIN; else go ISSUE_R1.
  - r2_valid never fires in the same cycle as the matching r1_valid, so there is at least 1 cycle between r1_valid and r2_valid.
- rnd_valid low stalls the current state indefinitely; no words are skipped.
- val_valid:
  - Push val into the FIFO; inflight−1. Accepted in any state.
  - When no sample is outstanding, the val is dropped and ignored.
  - Push with the FIFO full (must not occur) drops the value and sets err.
- Output:
  - FIFO is registered; out_valid rises 1 cycle after a push into an empty FIFO. No bypass.
  - Push and pop in the same cycle keep fifo_count unchanged, including at full.
  - out_idx = delivered count; increments on out_valid & out_ready.
- DRAIN: when delivered reaches N, done pulses one cycle, busy clears, go IDLE.
- logn=0: single sample, N=1.
- abort (any state, priority over all other events):
  - Next cycle: IDLE, FIFO empty, out_valid=0, busy=0, no done pulse.
  - In-flight vals arriving after abort are dropped; inflight is reset to 0. Post-abort vals are discarded by the drop rule above, not treated as overflow.
- Reset mid-batch: immediate return to reset values; the sampler is reset by the same rst_n.

Test Plan:
- logn=2, rnd_valid=1 constantly, out_ready=1, sampler vals 5,−3,0,−7 → r1/r2 pulses alternate for 4 pairs; out_data 5,−3,0,−7 with out_idx 0..3; done pulses once; busy=0 after.
- logn=3, out_ready=0 for 40 cycles → exactly 4 pairs issued, then rnd_ready=0 (FIFO_DEPTH=4); no err. On release, 8 samples delivered in order, idx 0..7.
- logn=1, rnd_valid toggling 1 cycle on / 3 cycles off → words consumed only on handshakes; r1 = 1st word, r2 = 2nd word, r1 = 3rd, r2 = 4th.
- start with logn=11 → err=1, busy stays 0. Then start with logn=0 → err cleared, one sample, done.
- abort mid-batch after 2 of 8 pairs issued → next cycle busy=0, out_valid=0, no done; late val_valid is ignored with err=0; a new start runs cleanly.
- rst_n low during ISSUE_R2 → all outputs 0 asynchronously; after release the block sits in IDLE with busy=0.
